// File: rtl/fir_channel_scheduler.sv
`default_nettype none
// fir_channel_scheduler: round-robin RED/IR front end sharing one folded 21-tap FIR MAC.
// Revision 1.0
module fir_channel_scheduler (
  input  logic        CLK_Filter,
  input  logic        rst_n,
  input  logic [7:0]  red_sample,
  input  logic        red_valid,
  output logic        red_ready,
  input  logic [7:0]  ir_sample,
  input  logic        ir_valid,
  output logic        ir_ready,
  input  logic        flush,
  output logic [19:0] out_data,
  output logic        out_ch,
  output logic        out_valid,
  output logic        busy
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_MAC  = 1'b1
  } state_t;

  localparam logic CH_RED = 1'b0;
  localparam logic CH_IR  = 1'b1;

  state_t      state_q, state_d;
  logic [7:0]  red_x_q [21];
  logic [7:0]  red_x_d [21];
  logic [7:0]  ir_x_q  [21];
  logic [7:0]  ir_x_d  [21];
  logic [7:0]  sel_x   [21];
  logic [4:0]  tap_q, tap_d;
  logic [19:0] acc_q, acc_d;
  logic [19:0] out_data_q, out_data_d;
  logic        ch_q, ch_d;
  logic        last_q, last_d;
  logic        out_ch_q, out_ch_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;

  logic        both_valid, accept_ok, red_hs, ir_hs;
  logic [8:0]  pair_sum;
  logic [16:0] product;
  logic [19:0] acc_next;

  function automatic logic [7:0] coef(input logic [4:0] j);
    case (j)
      5'd0:    coef = 8'd2;
      5'd1:    coef = 8'd10;
      5'd2:    coef = 8'd16;
      5'd3:    coef = 8'd28;
      5'd4:    coef = 8'd43;
      5'd5:    coef = 8'd60;
      5'd6:    coef = 8'd78;
      5'd7:    coef = 8'd95;
      5'd8:    coef = 8'd111;
      5'd9:    coef = 8'd122;
      default: coef = 8'd128;
    endcase
  endfunction

  // The channel served last loses a tie; with nothing offered both readies stay up.
  always_comb begin
    both_valid = red_valid & ir_valid;
    accept_ok  = (state_q == S_IDLE) & ~flush;
    red_ready  = accept_ok & ~(both_valid & (last_q == CH_RED));
    ir_ready   = accept_ok & ~(both_valid & (last_q == CH_IR));
    red_hs     = red_valid & red_ready;
    ir_hs      = ir_valid & ir_ready;
  end

  // Folded tap pair; the centre tap stands alone so the filter is a true 21-tap.
  always_comb begin
    for (int k = 0; k < 21; k++) begin
      sel_x[k] = ch_q ? ir_x_q[k] : red_x_q[k];
    end
    if (tap_q == 5'd10) begin
      pair_sum = {1'b0, sel_x[10]};
    end else begin
      pair_sum = {1'b0, sel_x[tap_q]} + {1'b0, sel_x[5'd20 - tap_q]};
    end
    product  = 17'(coef(tap_q)) * 17'(pair_sum);
    acc_next = acc_q + 20'(product);
  end

  always_comb begin
    state_d     = state_q;
    tap_d       = tap_q;
    acc_d       = acc_q;
    ch_d        = ch_q;
    last_d      = last_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    red_x_d     = red_x_q;
    ir_x_d      = ir_x_q;
    if (state_q == S_IDLE) begin
      if (flush) begin
        for (int k = 0; k < 21; k++) begin
          red_x_d[k] = 8'd0;
          ir_x_d[k]  = 8'd0;
        end
      end else if (red_hs || ir_hs) begin
        if (ir_hs) begin
          for (int k = 20; k > 0; k--) ir_x_d[k] = ir_x_q[k-1];
          ir_x_d[0] = ir_sample;
        end else begin
          for (int k = 20; k > 0; k--) red_x_d[k] = red_x_q[k-1];
          red_x_d[0] = red_sample;
        end
        ch_d    = ir_hs;
        last_d  = ir_hs;
        acc_d   = 20'd0;
        tap_d   = 5'd0;
        busy_d  = 1'b1;
        state_d = S_MAC;
      end
    end else begin
      acc_d = acc_next;
      tap_d = tap_q + 5'd1;
      if (tap_q == 5'd10) begin
        out_data_d  = acc_next;
        out_ch_d    = ch_q;
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = S_IDLE;
      end
    end
  end

  always_ff @(posedge CLK_Filter or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      tap_q       <= 5'd0;
      acc_q       <= 20'd0;
      ch_q        <= CH_RED;
      last_q      <= CH_IR;
      out_data_q  <= 20'd0;
      out_ch_q    <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      for (int k = 0; k < 21; k++) begin
        red_x_q[k] <= 8'd0;
        ir_x_q[k]  <= 8'd0;
      end
    end else begin
      state_q     <= state_d;
      tap_q       <= tap_d;
      acc_q       <= acc_d;
      ch_q        <= ch_d;
      last_q      <= last_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      red_x_q     <= red_x_d;
      ir_x_q      <= ir_x_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_channel_scheduler.sv
`default_nettype none
// tb_fir_channel_scheduler: directed vectors for the shared RED/IR FIR scheduler.
// Revision 1.0
module tb_fir_channel_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  red_sample = 8'd0;
  logic        red_valid = 1'b0;
  logic        red_ready;
  logic [7:0]  ir_sample = 8'd0;
  logic        ir_valid = 1'b0;
  logic        ir_ready;
  logic        flush = 1'b0;
  logic [19:0] out_data;
  logic        out_ch;
  logic        out_valid;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int h [21] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128,
                 122, 111, 95, 78, 60, 43, 28, 16, 10, 2};

  typedef struct {
    logic        ch;
    logic [7:0]  smp;
    logic [19:0] exp_data;
  } vec_t;

  vec_t vt [23];

  fir_channel_scheduler dut (
    .CLK_Filter (clk),
    .rst_n      (rst_n),
    .red_sample (red_sample),
    .red_valid  (red_valid),
    .red_ready  (red_ready),
    .ir_sample  (ir_sample),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .flush      (flush),
    .out_data   (out_data),
    .out_ch     (out_ch),
    .out_valid  (out_valid),
    .busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int prefix(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += h[i];
    return s;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    red_valid = 1'b0;
    ir_valid = 1'b0;
    flush = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out_data", 32'(out_data), 0);
    chk("reset_out_ch", 32'(out_ch), 0);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_busy", 32'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Offer one sample at a negedge and return #1 after the accepting edge.
  task automatic hs(input logic ch, input logic [7:0] s);
    int wt = 0;
    if (ch) begin ir_sample = s; ir_valid = 1'b1; end
    else    begin red_sample = s; red_valid = 1'b1; end
    #1;
    while (!(ch ? ir_ready : red_ready) && wt < 30) begin
      @(negedge clk);
      wt++;
    end
    if (wt >= 30) chk("hs_timeout", 32'(wt), 0);
    @(posedge clk);
    #1;
    if (ch) ir_valid = 1'b0;
    else    red_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [19:0] exp, input logic exp_ch,
                             input int exp_lat, input bit check_low, output logic [19:0] got);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n <= 20);
    got = out_data;
    chk({name, "_latency"}, 32'(n), 32'(exp_lat));
    chk({name, "_data"}, 32'(out_data), 32'(exp));
    chk({name, "_ch"}, 32'(out_ch), 32'(exp_ch));
    if (check_low) begin
      @(negedge clk);
      chk({name, "_strobe_low"}, 32'(out_valid), 0);
    end
  endtask

  initial begin
    logic [19:0] got, prev;
    logic [7:0]  tr_red [3];
    logic [7:0]  tr_ir  [3];
    logic [19:0] ex_red [3];
    logic [19:0] ex_ir  [3];
    int ri, ii, prev_cyc, wt, cnt;
    logic g_ir;

    for (int i = 0; i < 23; i++) begin
      vt[i].ch       = 1'b0;
      vt[i].smp      = (i == 0) ? 8'd255 : 8'd0;
      vt[i].exp_data = (i < 21) ? 20'(255 * h[i]) : 20'd0;
    end
    tr_red = '{8'd255, 8'd0, 8'd0};
    ex_red = '{20'd510, 20'd2550, 20'd4080};
    tr_ir  = '{8'd100, 8'd100, 8'd100};
    ex_ir  = '{20'd200, 20'd1200, 20'd2800};

    // RED impulse response
    do_reset();
    for (int i = 0; i < 23; i++) begin
      hs(vt[i].ch, vt[i].smp);
      wait_result("red_impulse", vt[i].exp_data, vt[i].ch, 12, 1, got);
    end

    // IR full scale ramp
    do_reset();
    prev = 20'd0;
    for (int i = 0; i < 21; i++) begin
      hs(1'b1, 8'd255);
      wait_result("ir_fullscale", 20'(255 * prefix(i + 1)), 1'b1, 12, 1, got);
      chk("ir_monotonic", 32'(got > prev), 1);
      prev = got;
    end
    chk("ir_fullscale_final", 32'(got), 32'd320790);

    // Tie arbitration: both valid from reset
    do_reset();
    ri = 0; ii = 0; prev_cyc = 0;
    red_sample = tr_red[0]; ir_sample = tr_ir[0];
    red_valid = 1'b1; ir_valid = 1'b1;
    #1;
    for (int g = 0; g < 6; g++) begin
      g_ir = (g % 2) == 1;
      wt = 0;
      while (!((red_valid & red_ready) | (ir_valid & ir_ready)) && wt < 30) begin
        @(negedge clk);
        wt++;
      end
      chk("tie_grant", {30'd0, red_valid & red_ready, ir_valid & ir_ready}, g_ir ? 32'd1 : 32'd2);
      @(posedge clk);
      #1;
      if (g > 0) chk("tie_interval", 32'(cyc - prev_cyc), 12);
      prev_cyc = cyc;
      if (g_ir) begin
        ii++;
        if (ii < 3) ir_sample = tr_ir[ii]; else ir_valid = 1'b0;
        wait_result("tie_ir", ex_ir[ii-1], 1'b1, 12, 0, got);
      end else begin
        ri++;
        if (ri < 3) red_sample = tr_red[ri]; else red_valid = 1'b0;
        wait_result("tie_red", ex_red[ri-1], 1'b0, 12, 0, got);
      end
    end
    red_valid = 1'b0; ir_valid = 1'b0;
    @(negedge clk);

    // Flush in IDLE
    do_reset();
    for (int i = 0; i < 10; i++) begin
      hs(1'b0, 8'd100);
      wait_result("flush_load", 20'(100 * prefix(i + 1)), 1'b0, 12, 1, got);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    hs(1'b0, 8'd100);
    wait_result("flush_idle", 20'd200, 1'b0, 12, 1, got);

    // Flush during MAC is ignored
    hs(1'b0, 8'd100);
    repeat (2) @(negedge clk);
    flush = 1'b1;
    repeat (3) @(negedge clk);
    flush = 1'b0;
    wait_result("flush_mac", 20'd1200, 1'b0, 7, 1, got);

    // Reset mid-MAC at step j = 5
    do_reset();
    hs(1'b0, 8'd255);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_data", 32'(out_data), 0);
    chk("midrst_out_ch", 32'(out_ch), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (15) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    chk("midrst_no_strobe", 32'(cnt), 0);
    hs(1'b0, 8'd255);
    wait_result("midrst_after", 20'd510, 1'b0, 12, 1, got);

    // Backpressure: IR held through a RED sequence
    do_reset();
    hs(1'b0, 8'd50);
    ir_sample = 8'd80;
    ir_valid = 1'b1;
    cnt = 0;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      if (n < 12 && ir_ready) cnt++;
    end
    chk("bp_ready_low", 32'(cnt), 0);
    chk("bp_ready_idle", 32'(ir_ready), 1);
    chk("bp_red_valid", 32'(out_valid), 1);
    chk("bp_red_data", 32'(out_data), 32'd100);
    @(posedge clk);
    #1;
    ir_valid = 1'b0;
    wait_result("bp_ir", 20'd160, 1'b1, 12, 1, got);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_channel_scheduler.md
# fir_channel_scheduler

Time-multiplexed controller that shares one symmetric 21-tap FIR multiply-accumulate engine between the RED and IR photodiode sample streams of the pulse-oximeter front end. It accepts 8-bit ADC samples from both channels over valid/ready handshakes and arbitrates between them round-robin. It keeps a separate 21-deep delay line per channel, sequences the 11 folded MAC steps, and emits a 20-bit filtered result tagged with its channel. It sits between the LED/ADC sampling logic and the downstream SpO2 ratio computation, and replaces the two per-channel fully parallel filters.

## Interface
- No parameters. Coefficients are fixed: c[0..10] = 2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128 (c[10] is the centre tap).
- Reset is `rst_n`, asynchronous, active-low. The clock is `CLK_Filter`.
- `CLK_Filter`  in  1  filter clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `red_sample`  in  8  RED ADC sample.
- `red_valid`  in  1  RED sample offered.
- `red_ready`  out  1  RED sample accepted this cycle when high together with `red_valid`.
- `ir_sample`  in  8  IR ADC sample.
- `ir_valid`  in  1  IR sample offered.
- `ir_ready`  out  1  IR sample accepted this cycle when high together with `ir_valid`.
- `flush`  in  1  clears both delay lines; honoured only in IDLE.
- `out_data`  out  20  filtered result, unsigned.
- `out_ch`  out  1  channel of `out_data`: 0 = RED, 1 = IR.
- `out_valid`  out  1  one-cycle strobe marking a new result.
- `busy`  out  1  high while a MAC sequence is in progress.

## Operation
- State machine has two states: IDLE and MAC.
- IDLE transitions to MAC on a handshake. MAC transitions back to IDLE after the 11th step.
- **Ready logic** (combinational; both `ready` outputs are 0 outside IDLE and 0 while `flush` is high):
  - If only one channel is valid, that channel's `ready` is 1.
  - If both are valid, only the channel not served last gets `ready`.
  - If neither is valid, both `ready` outputs are 1.
- **Round-robin pointer `last`:** reset value = IR, so RED wins the first tie. `last` updates on every accepted handshake.
- **Handshake edge (IDLE):**
  - Shift the sample into the selected channel's line: x[k] ← x[k-1] for k = 20..1, then x[0] ← sample.
  - Clear the accumulator, set tap index j = 0, latch the channel, enter MAC.
  - The other channel's delay line is untouched.
- **MAC step j (0..9):** acc += c[j] × (x[j] + x[20−j]). The pair sum is 9 bits and the product is 17 bits.
- **MAC step j = 10:** acc += c[10] × x[10]. This is a true 21-tap filter; the centre tap is not doubled.
- **Width rules:**
  - Worst case is 255 × 1258 = 320790, so the 20-bit accumulator never overflows and no saturation logic is needed.
  - DC gain = 1258.
- **After step 10:**
  - `out_data` ← final acc and `out_ch` ← latched channel.
  - `out_valid` pulses for the following cycle; state → IDLE.
  - `out_data` and `out_ch` hold until the next result.
- **`flush` in IDLE:** all 42 delay-line entries are cleared on the next edge. Flush takes priority over any handshake in that cycle.
- **`flush` while in MAC:** ignored. It must be held or re-asserted in IDLE to take effect.
- **Reset (including mid-MAC):**
  - Aborts the sequence with no `out_valid`.
  - Reset values: delay lines 0, acc 0, `out_data` 0, `out_ch` 0, `out_valid` 0, `busy` 0, state IDLE, `last` = IR.

## Timing
- Handshake at edge E0. MAC steps execute on edges E1..E11.
- The result is registered at E11. `out_valid` is high from E11 to E12.
- `busy` is high from E0 to E11.
- The next handshake is possible at E12 (first IDLE cycle). Throughput is 1 sample per 12 cycles, shared by both channels.
- When both channels are continuously valid, grants strictly alternate RED, IR, RED, and so on.
- A sample offered during MAC waits (`valid` held, `ready` = 0) without loss.
- `out_valid` never occurs in the same cycle as a handshake.

## Test plan
- **RED impulse response.** After reset, feed RED 255 then twenty-two 0 samples; IR stays idle.
  - The first 21 results must be 255 × h, with h = 2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128, 122, …, 2 (e.g. 510, 2550, …, 32640 at the 11th).
  - The 22nd and 23rd results must be 0, and every result must have `out_ch` = 0.
- **IR full scale.** Feed IR 255 × 21.
  - The 21st result must be 320790 (0x4E516) with `out_ch` = 1.
  - The results before it ramp monotonically.
- **Tie arbitration.** Assert `red_valid` and `ir_valid` together from reset.
  - Grants go RED first, then alternate.
  - Handshakes are exactly 12 cycles apart.
  - Each channel's outputs equal its single-channel reference sequence (channel isolation).
- **Flush.**
  - Load 10 RED samples of 100, then flush in IDLE. The next RED sample of 100 must yield 200 (c[0] × 100).
  - Flush asserted during MAC must not alter the in-flight result.
- **Reset mid-MAC.** Deassert `rst_n` at step j = 5.
  - No `out_valid` may be produced.
  - All outputs must be 0.
  - A following RED 255 must yield 510.
- **Backpressure.** Hold `ir_valid` through a RED MAC sequence.
  - `ir_ready` must be 0 until the first IDLE cycle.
  - The IR sample must then be accepted, its result appearing 12 cycles later.
